// File: rtl/booth_mul32_pkg.sv
// Shared definitions for the radix-2 Booth multiplier slice.
//  - state_e   : FSM state encoding (IDLE/EXEC/DONE, 2-bit)
//  - MUL_WIDTH : operand width, tied to the cla32 datapath
//  - MUL_ITER  : number of Booth iterations per product
//  - booth_op  : decodes a Booth bit pair into add/sub enables
package booth_mul32_pkg;

  localparam int MUL_WIDTH = 32;
  localparam int MUL_ITER  = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic add_en;  // an add or subtract happens this iteration
    logic sub;     // subtract (b = ~M, ci = 1)
  } booth_op_t;

  // Pair is {q_i, q_(i-1)}: 01 -> +M, 10 -> -M, 00/11 -> no operation.
  function automatic booth_op_t booth_op(input logic [1:0] pair);
    booth_op_t op;
    op.add_en = pair[1] ^ pair[0];
    op.sub    = pair[1] & ~pair[0];
    return op;
  endfunction

endpackage

// File: rtl/booth_mul32_cla32.sv
// cla32: 32-bit carry-lookahead adder.
//  Eight 4-bit lookahead groups; group carries ripple between groups.
//  Ports:
//   a   in  32  addend
//   b   in  32  addend
//   ci  in  1   carry in
//   sum out 32  a + b + ci (carry-out is not needed by the multiplier)
module cla32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  output logic [31:0] sum
);

  logic [31:0] g;
  logic [31:0] p;
  logic [3:0]  gg;
  logic [3:0]  pp;
  logic [3:0]  c4;
  logic        carry;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    sum   = '0;
    gg    = '0;
    pp    = '0;
    c4    = '0;
    carry = ci;
    for (int k = 0; k < 8; k++) begin
      gg    = g[4*k +: 4];
      pp    = p[4*k +: 4];
      c4[0] = carry;
      c4[1] = gg[0] | (pp[0] & carry);
      c4[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & carry);
      c4[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
            | (pp[2] & pp[1] & pp[0] & carry);
      sum[4*k +: 4] = pp ^ c4;
      // Group generate / propagate produce the carry into the next group.
      carry = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
            | (pp[3] & pp[2] & pp[1] & gg[0])
            | (pp[3] & pp[2] & pp[1] & pp[0] & carry);
    end
  end

endmodule

// File: rtl/booth_mul32.sv
// booth_mul32: multi-cycle 32x32 signed multiplier, radix-2 Booth, one
// add/sub per cycle through a cla32 instance, 32 iterations per product.
//  Ports:
//   clk          in   1   clock, rising edge
//   reset        in   1   asynchronous active-high reset
//   op_start     in   1   start request
//   op_clear     in   1   synchronous abort/clear, wins over op_start
//   multiplicand in   32  M (two's complement)
//   multiplier   in   32  Q (two's complement)
//   busy         out  1   iterating (EXEC)
//   op_done      out  1   product valid in result (DONE)
//   result       out  64  registered signed product
//   dbg_state    out  2   current FSM state
//
// Handshake: op_start is a level request that is accepted on a rising edge
// only when the FSM is in IDLE or DONE and op_clear is low; operands are
// captured on that same edge. Requests in EXEC are dropped, not queued.
// busy covers the 32 iteration cycles; op_done stays high (result stable)
// until the next accepted op_start or an op_clear.
module booth_mul32
  import booth_mul32_pkg::*;
#(
  parameter int WIDTH    = MUL_WIDTH,
  parameter int CNT_BITS = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               op_start,
  input  logic               op_clear,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               op_done,
  output logic [2*WIDTH-1:0] result,
  output state_e             dbg_state
);

  localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(MUL_ITER - 1);

  state_e               state_q, state_d;
  logic [2*WIDTH:0]     p_q, p_d;        // {upper, multiplier bits, q_-1}
  logic [WIDTH-1:0]     m_q, m_d;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   result_q, result_d;

  booth_op_t            op;
  logic [WIDTH-1:0]     cla_a;
  logic [WIDTH-1:0]     cla_b;
  logic [WIDTH-1:0]     cla_sum;
  logic [WIDTH-1:0]     upper;
  logic                 ovf;
  logic                 sign_in;
  logic [2*WIDTH:0]     shifted;

  // Booth decode and adder operand selection.
  assign op    = booth_op(p_q[1:0]);
  assign cla_a = p_q[2*WIDTH:WIDTH+1];
  assign cla_b = op.sub ? ~m_q : m_q;

  cla32 u_cla32 (
    .a   (cla_a),
    .b   (cla_b),
    .ci  (op.sub),
    .sum (cla_sum)
  );

  // The 32-bit sum can overflow (e.g. M = 0x8000_0000); the shifted-in sign
  // must be the sign of the true 33-bit result, so flip sum[31] on overflow.
  assign upper   = op.add_en ? cla_sum : cla_a;
  assign ovf     = op.add_en & (cla_a[WIDTH-1] == cla_b[WIDTH-1])
                 & (cla_sum[WIDTH-1] != cla_a[WIDTH-1]);
  assign sign_in = upper[WIDTH-1] ^ ovf;
  assign shifted = {sign_in, upper, p_q[WIDTH:1]};

  always_comb begin
    state_d  = state_q;
    p_d      = p_q;
    m_d      = m_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    if (op_clear) begin
      state_d  = S_IDLE;
      p_d      = '0;
      cnt_d    = '0;
      result_d = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (op_start) begin
            state_d = S_EXEC;
            p_d     = {{WIDTH{1'b0}}, multiplier, 1'b0};
            m_d     = multiplicand;
            cnt_d   = '0;
          end
        end
        S_EXEC: begin
          p_d   = shifted;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_d  = S_DONE;
            result_d = shifted[2*WIDTH:1];
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      p_q      <= '0;
      m_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      m_q      <= m_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign busy      = (state_q == S_EXEC);
  assign op_done   = (state_q == S_DONE);
  assign result    = result_q;
  assign dbg_state = state_q;

endmodule
